// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller behind the memory stage.
// Captures a load/store request, waits WAIT_STATES cycles, accesses an
// internal word-organised RAM and returns the raw load word with a
// one-cycle rvalid pulse. stall holds the core while an access is in flight.
// Optional feature: define DMEM_BOUNDS_CHECK_EN to flag and suppress
// out-of-range accesses (err); otherwise addresses wrap and err is 0.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_request,
    input  logic        we_re,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  mask,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        stall,
    output logic        err
);

    localparam int         AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_mask;
    logic        cap_we;

    logic [31:0] mem [DEPTH_WORDS];

    // Access-side view: with zero wait states the access happens on the
    // capture edge itself, so the live inputs stand in for the captured ones.
    logic          access;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_mask;
    logic          acc_we;
    logic [AW-1:0] word_idx;
    logic          oor;
    logic          unused_addr_bits;

    // Select access operands and detect the edge that enters RESP
    always_comb begin
        access    = 1'b0;
        acc_addr  = cap_addr;
        acc_wdata = cap_wdata;
        acc_mask  = cap_mask;
        acc_we    = cap_we;
        if (state == IDLE) begin
            access    = mem_request && (WS == 4'd0);
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_mask  = mask;
            acc_we    = we_re;
        end else if (state == WAIT) begin
            access = (cnt == 4'd1);
        end
    end

    assign word_idx = acc_addr[AW+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
    assign oor = ({1'b0, acc_addr} >= LIMIT);
`else
    assign oor = 1'b0;
`endif

    // Byte offset and (when wrapping) upper address bits do not select a word
    assign unused_addr_bits = &{1'b0, acc_addr[31:AW+2], acc_addr[1:0]};

    assign stall = ((state == IDLE) && mem_request) || (state == WAIT);

    // Capture the request operands when a request is accepted in IDLE
    always_ff @(posedge clk) begin
        if (state == IDLE && mem_request) begin
            cap_addr  <= addr;
            cap_wdata <= wdata;
            cap_mask  <= mask;
            cap_we    <= we_re;
        end
    end

    // RAM byte-lane write; gated by rst_n so an aborted store never lands
    always_ff @(posedge clk) begin
        if (rst_n && access && acc_we && !oor) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_mask[i]) begin
                    mem[word_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Request FSM with registered completion outputs and load data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= 32'd0;
        end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_request) begin
                        cnt   <= WS;
                        state <= (WS == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (access) begin
                rvalid <= 1'b1;
                err    <= oor;
                if (!acc_we) begin
                    rdata <= oor ? 32'd0 : mem[word_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench for dmem_ctrl with one instance at
// WAIT_STATES=1 and one at WAIT_STATES=0 sharing data inputs and reset.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req1, req0;
    logic        we_re;
    logic [31:0] addr, wdata;
    logic [3:0]  mask;
    logic [31:0] rdata1, rdata0;
    logic        rvalid1, rvalid0, stall1, stall0, err1, err0;

    int checks = 0;
    int errors = 0;

    dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_request(req1), .we_re(we_re),
        .addr(addr), .wdata(wdata), .mask(mask), .rdata(rdata1),
        .rvalid(rvalid1), .stall(stall1), .err(err1)
    );

    dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_request(req0), .we_re(we_re),
        .addr(addr), .wdata(wdata), .mask(mask), .rdata(rdata0),
        .rvalid(rvalid0), .stall(stall0), .err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // One access on dut1 (WAIT_STATES=1); operands are scrambled after capture
    task automatic acc1(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        input logic [31:0] exp_rd, input logic exp_err);
        cyc();
        req1 = 1'b1; we_re = w; addr = a; wdata = d; mask = m;
        smp();
        chk({tag, "_c0_stall"}, {31'd0, stall1}, 32'd1);
        chk({tag, "_c0_rvalid"}, {31'd0, rvalid1}, 32'd0);
        cyc();
        we_re = ~w; addr = ~a; wdata = ~d; mask = 4'hF;
        smp();
        chk({tag, "_c1_stall"}, {31'd0, stall1}, 32'd1);
        chk({tag, "_c1_rvalid"}, {31'd0, rvalid1}, 32'd0);
        cyc();
        smp();
        chk({tag, "_c2_stall"}, {31'd0, stall1}, 32'd0);
        chk({tag, "_c2_rvalid"}, {31'd0, rvalid1}, 32'd1);
        chk({tag, "_c2_rdata"}, rdata1, exp_rd);
        chk({tag, "_c2_err"}, {31'd0, err1}, {31'd0, exp_err});
        cyc();
        req1 = 1'b0;
        smp();
        chk({tag, "_c3_rvalid"}, {31'd0, rvalid1}, 32'd0);
        chk({tag, "_c3_stall"}, {31'd0, stall1}, 32'd0);
        chk({tag, "_c3_err"}, {31'd0, err1}, 32'd0);
        chk({tag, "_c3_rdata_hold"}, rdata1, exp_rd);
    endtask

    initial begin
        rst_n = 1'b0; req1 = 1'b0; req0 = 1'b0; we_re = 1'b0;
        addr = 32'd0; wdata = 32'd0; mask = 4'd0;

        // Reset state
        cyc(); cyc();
        smp();
        chk("rst_rdata", rdata1, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid1}, 32'd0);
        chk("rst_stall", {31'd0, stall1}, 32'd0);
        chk("rst_err", {31'd0, err1}, 32'd0);
        cyc();
        rst_n = 1'b1;
        smp();
        chk("idle_rdata", rdata1, 32'd0);
        chk("idle_stall", {31'd0, stall1}, 32'd0);
        chk("idle_rvalid", {31'd0, rvalid1}, 32'd0);

        // Full-word store then load with byte offset ignored
        acc1("st_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'd0, 1'b0);
        acc1("ld_13", 1'b0, 32'h13, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);

        // Partial lane store and masked-off store
        acc1("st_lane1", 1'b1, 32'h10, 32'h0000AA00, 4'b0010, 32'hDEADBEEF, 1'b0);
        acc1("ld_lane1", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADAAEF, 1'b0);
        acc1("st_mask0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'hDEADAAEF, 1'b0);
        acc1("ld_mask0", 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADAAEF, 1'b0);

        // Reset during WAIT of a store discards it
        acc1("st_20", 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, 32'hDEADAAEF, 1'b0);
        cyc();
        req1 = 1'b1; we_re = 1'b1; addr = 32'h20; wdata = 32'h12345678; mask = 4'hF;
        smp();
        chk("abort_c0_stall", {31'd0, stall1}, 32'd1);
        cyc();
        rst_n = 1'b0; req1 = 1'b0;
        smp();
        chk("abort_rst_stall", {31'd0, stall1}, 32'd0);
        chk("abort_rst_rvalid", {31'd0, rvalid1}, 32'd0);
        chk("abort_rst_rdata", rdata1, 32'd0);
        cyc();
        smp();
        chk("abort_rst_rvalid2", {31'd0, rvalid1}, 32'd0);
        cyc();
        rst_n = 1'b1;
        smp();
        chk("abort_rel_rvalid", {31'd0, rvalid1}, 32'd0);
        acc1("ld_20", 1'b0, 32'h20, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0);

        // Out-of-range load
        acc1("st_0", 1'b1, 32'h0, 32'h11223344, 4'b1111, 32'hCAFEF00D, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
        acc1("ld_1000", 1'b0, 32'h1000, 32'h0, 4'b0000, 32'h0, 1'b1);
`else
        acc1("ld_1000", 1'b0, 32'h1000, 32'h0, 4'b0000, 32'h11223344, 1'b0);
`endif

        // Zero wait states: store, then two back-to-back loads
        cyc();
        req0 = 1'b1; we_re = 1'b1; addr = 32'h40; wdata = 32'hA5A5A5A5; mask = 4'hF;
        smp();
        chk("ws0_st_c0_stall", {31'd0, stall0}, 32'd1);
        chk("ws0_st_c0_rvalid", {31'd0, rvalid0}, 32'd0);
        cyc();
        smp();
        chk("ws0_st_c1_rvalid", {31'd0, rvalid0}, 32'd1);
        chk("ws0_st_c1_stall", {31'd0, stall0}, 32'd0);
        cyc();
        we_re = 1'b0; addr = 32'h40;
        smp();
        chk("ws0_ld_c0_stall", {31'd0, stall0}, 32'd1);
        chk("ws0_ld_c0_rvalid", {31'd0, rvalid0}, 32'd0);
        cyc();
        smp();
        chk("ws0_ld_c1_rvalid", {31'd0, rvalid0}, 32'd1);
        chk("ws0_ld_c1_stall", {31'd0, stall0}, 32'd0);
        chk("ws0_ld_c1_rdata", rdata0, 32'hA5A5A5A5);
        cyc();
        addr = 32'h41;
        smp();
        chk("ws0_ld_c2_stall", {31'd0, stall0}, 32'd1);
        chk("ws0_ld_c2_rvalid", {31'd0, rvalid0}, 32'd0);
        cyc();
        smp();
        chk("ws0_ld_c3_rvalid", {31'd0, rvalid0}, 32'd1);
        chk("ws0_ld_c3_stall", {31'd0, stall0}, 32'd0);
        chk("ws0_ld_c3_rdata", rdata0, 32'hA5A5A5A5);
        chk("ws0_ld_c3_err", {31'd0, err0}, 32'd0);
        cyc();
        req0 = 1'b0;
        smp();
        chk("ws0_c4_rvalid", {31'd0, rvalid0}, 32'd0);
        chk("ws0_c4_stall", {31'd0, stall0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
